// File: rtl/sr_drive_pkg.sv
// Shared types and helpers for the sr_flipflop drive controller.
package sr_drive_pkg;

  typedef enum logic [2:0] {
    INIT_CLR,
    IDLE,
    DRIVE_S,
    DRIVE_R,
    DEAD
  } state_t;

  typedef enum logic {
    OP_SET,
    OP_CLR
  } op_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sr_drive_timer.sv
// Loadable down-counter; done flags count==1 and the count saturates at 0.
module sr_drive_timer
  import sr_drive_pkg::*;
#(
  parameter int unsigned CNT_W   = 2,
  parameter int unsigned RST_VAL = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= CNT_W'(RST_VAL);
    end else if (load) begin
      count_q <= load_val;
    end else if (count_q != '0) begin
      count_q <= count_q - CNT_W'(1);
    end
  end

  assign done = (count_q == CNT_W'(1));

endmodule

// File: rtl/sr_drive_ctrl.sv
// Command stage generating exclusive s/r pulses for sr_flipflop, with dead time and a q mirror.
// Optional macro SR_DRIVE_SKIP_REDUNDANT_EN suppresses pulses that would not change the latch.
module sr_drive_ctrl
  import sr_drive_pkg::*;
#(
  parameter int unsigned PULSE_W = 2,
  parameter int unsigned DEAD_W  = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic set_req,
  input  logic clr_req,
  output logic req_ready,
  output logic s,
  output logic r,
  output logic busy,
  output logic q_mirror,
  output logic err_both
);

  localparam int unsigned CNT_W = $clog2(max_u(PULSE_W, DEAD_W) + 1);
  localparam state_t POST_PULSE = (DEAD_W > 0) ? DEAD : IDLE;

  state_t           state_q, state_d;
  logic             s_q, s_d;
  logic             r_q, r_d;
  logic             q_mirror_q, q_mirror_d;
  logic             err_q, err_d;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_done;
  op_t              req_op;
  logic             redundant;

  sr_drive_timer #(
    .CNT_W  (CNT_W),
    .RST_VAL(PULSE_W)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (tmr_load),
    .load_val(tmr_val),
    .done    (tmr_done)
  );

  assign req_op = set_req ? OP_SET : OP_CLR;

`ifdef SR_DRIVE_SKIP_REDUNDANT_EN
  assign redundant = ((req_op == OP_SET) == q_mirror_q);
`else
  assign redundant = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    s_d        = s_q;
    r_d        = r_q;
    q_mirror_d = q_mirror_q;
    err_d      = 1'b0;
    tmr_load   = 1'b0;
    tmr_val    = CNT_W'(PULSE_W);

    unique case (state_q)
      INIT_CLR: begin
        s_d = 1'b0;
        // First cycle after reset only raises r; the timer starts counting once r is high.
        if (!r_q) begin
          r_d      = 1'b1;
          tmr_load = 1'b1;
        end else if (tmr_done) begin
          r_d        = 1'b0;
          q_mirror_d = 1'b0;
          state_d    = POST_PULSE;
          tmr_load   = 1'b1;
          tmr_val    = CNT_W'(DEAD_W);
        end
      end

      IDLE: begin
        s_d = 1'b0;
        r_d = 1'b0;
        if (set_req && clr_req) begin
          err_d = 1'b1;
        end else if ((set_req ^ clr_req) && !redundant) begin
          tmr_load = 1'b1;
          if (req_op == OP_SET) begin
            state_d = DRIVE_S;
            s_d     = 1'b1;
          end else begin
            state_d = DRIVE_R;
            r_d     = 1'b1;
          end
        end
      end

      DRIVE_S: begin
        if (tmr_done) begin
          s_d        = 1'b0;
          q_mirror_d = 1'b1;
          state_d    = POST_PULSE;
          tmr_load   = 1'b1;
          tmr_val    = CNT_W'(DEAD_W);
        end
      end

      DRIVE_R: begin
        if (tmr_done) begin
          r_d        = 1'b0;
          q_mirror_d = 1'b0;
          state_d    = POST_PULSE;
          tmr_load   = 1'b1;
          tmr_val    = CNT_W'(DEAD_W);
        end
      end

      DEAD: begin
        if (tmr_done) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d  = INIT_CLR;
        s_d      = 1'b0;
        r_d      = 1'b0;
        tmr_load = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= INIT_CLR;
      s_q        <= 1'b0;
      r_q        <= 1'b0;
      q_mirror_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      s_q        <= s_d;
      r_q        <= r_d;
      q_mirror_q <= q_mirror_d;
      err_q      <= err_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign s         = s_q;
  assign r         = r_q;
  assign q_mirror  = q_mirror_q;
  assign err_both  = err_q;

endmodule
